bus_rr_sched: RTL and testbench
===============================

BUS_RR_SCHED -- requirements
Module: bus_rr_sched

Interface
REQ-001 The block SHALL have parameter drvrs, default 4, meaning number of bus devices (2..16).
REQ-002 The block SHALL have parameter pckg_sz, default 16, meaning packet width in bits (>= 9).
REQ-003 The block SHALL have parameter broadcast, default 8'hFF, meaning destination ID that addresses all devices.
REQ-004 The block SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port pndng  input  drvrs  per-device "source FIFO non-empty".
REQ-007 The block SHALL have port D_pop  input  drvrs*pckg_sz  per-device FIFO head data, first-word-fall-through; device i occupies bits [i*pckg_sz +: pckg_sz].
REQ-008 The block SHALL have port pop  output  drvrs  one-hot, one-cycle pop strobe to the granted source.
REQ-009 The block SHALL have port push  output  drvrs  one-cycle push strobe(s) to destination device(s).
REQ-010 The block SHALL have port D_push  output  pckg_sz  packet driven to all destinations, valid while push is non-zero.
REQ-011 The block SHALL have port gnt_id  output  4  index of the current or last granted source.
REQ-012 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 The block SHALL have port drop_cnt  output  8  count of dropped packets (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, POP, XFER; all outputs SHALL be registered.
REQ-015 In IDLE with pndng != 0, the block SHALL select the first set pndng bit searching from (last_gnt+1) modulo drvrs upward with wrap, load gnt_id, and go to POP.
REQ-016 In IDLE with pndng == 0, the block SHALL stay in IDLE with pop = 0 and push = 0.
REQ-017 In POP, pop[gnt_id] SHALL be 1 for exactly one cycle, D_pop of gnt_id SHALL be captured at the end of that cycle, and the FSM SHALL go to XFER.
REQ-018 The destination ID SHALL be captured bits [pckg_sz-1 -: 8].
REQ-019 In XFER with dest < drvrs and dest != gnt_id, push[dest] SHALL be 1 for one cycle and D_push SHALL equal the captured packet.
REQ-020 In XFER with dest == broadcast, push SHALL be all ones except bit gnt_id, for one cycle.
REQ-021 In XFER with an invalid destination (>= drvrs, != broadcast, or == gnt_id), push SHALL stay 0, the packet SHALL be dropped, and drop_cnt SHALL increment.
REQ-022 drop_cnt SHALL saturate at 8'hFF.
REQ-023 After XFER the FSM SHALL return to IDLE and last_gnt SHALL become gnt_id.
REQ-024 Latency SHALL be: pndng sampled at edge k, pop high in cycle k+1, push high in cycle k+2.
REQ-025 Peak throughput SHALL be one packet per 3 cycles.
REQ-026 A pndng bit deasserting during POP or XFER SHALL NOT abort the transfer already in progress.
REQ-027 D_push SHALL hold its last value when push is 0.

Reset
REQ-028 While reset is 1 at a rising edge: state SHALL be IDLE, pop = 0, push = 0, D_push = 0, gnt_id = drvrs-1 (so the first search starts at device 0), busy = 0, drop_cnt = 0.
REQ-029 Reset asserted in POP or XFER SHALL abandon the packet with no push issued; a popped packet is lost.
REQ-030 In the first cycle after reset deasserts, the block SHALL perform IDLE evaluation.

Configuration
REQ-031 Macro BUS_SCHED_DROP_CNT_EN defined: drop_cnt SHALL count per REQ-021/022.
REQ-032 Macro BUS_SCHED_DROP_CNT_EN undefined: drop_cnt SHALL be constant 0 and no counter logic SHALL be synthesized; drop behaviour (REQ-021) SHALL be unchanged.

Verification
REQ-033 Unicast: drvrs=4, reset, pndng=4'b0010, D_pop[1]=16'h02AB -> pop=4'b0010 one cycle, next cycle push=4'b0100, D_push=16'h02AB.
REQ-034 Round-robin fairness: pndng=4'b1111 held, each source queues 2 packets -> grant order 0,1,2,3,0,1,2,3 with no source granted twice in a row.
REQ-035 Broadcast: source 2 sends 16'hFF55 -> push=4'b1011 for one cycle, D_push=16'hFF55.
REQ-036 Drops: source 0 sends 16'h0700 (dest 7) then 16'h0011 (dest 0, self) -> push stays 0, drop_cnt = 2 (0 with macro undefined).
REQ-037 Reset mid-transfer: assert reset during the POP cycle -> no push, all outputs at reset values, next grant starts from device 0.
REQ-038 Saturation: 300 invalid-destination packets -> drop_cnt = 8'hFF.

Source files
------------

// File: rtl/bus_rr_sched.sv
// bus_rr_sched: round-robin bus scheduler.
// Pops one packet at a time from the granted source FIFO and pushes it to the
// destination named in the packet's top byte (unicast or broadcast).
// Packets with an unreachable destination are dropped.
// Optional feature macro: BUS_SCHED_DROP_CNT_EN enables the saturating
// drop_cnt counter; when undefined, drop_cnt is tied to zero.
module bus_rr_sched #(
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic [3:0]               gnt_id,
  output logic                     busy,
  output logic [7:0]               drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t state_q;

  // Per-device views padded to 16 entries so the 4-bit grant index always
  // addresses a real element.
  logic [15:0]        pndng_ext;
  logic [pckg_sz-1:0] d_pop_arr [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_slice
      if (gi < drvrs) begin : g_dev
        assign d_pop_arr[gi] = D_pop[gi*pckg_sz +: pckg_sz];
        assign pndng_ext[gi] = pndng[gi];
      end else begin : g_pad
        assign d_pop_arr[gi] = '0;
        assign pndng_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Round-robin search: first requester after the last grant, with wrap.
  // Iterating from the farthest offset down lets the nearest one win.
  logic [3:0] sel_d;
  logic       sel_vld;
  logic [4:0] srch_idx;

  always_comb begin
    sel_d    = gnt_id;
    sel_vld  = 1'b0;
    srch_idx = '0;
    for (int off = drvrs; off >= 1; off--) begin
      srch_idx = {1'b0, gnt_id} + 5'(off);
      if (srch_idx >= 5'(drvrs)) begin
        srch_idx = srch_idx - 5'(drvrs);
      end
      if (pndng_ext[srch_idx[3:0]]) begin
        sel_d   = srch_idx[3:0];
        sel_vld = 1'b1;
      end
    end
  end

  // Head packet of the granted source and its routing decision.
  logic [pckg_sz-1:0] pkt_w;
  logic [7:0]         dest_w;
  logic               is_bcast;
  logic               is_uni;
  logic [drvrs-1:0]   pop_d;
  logic [drvrs-1:0]   push_d;

  assign pkt_w    = d_pop_arr[gnt_id];
  assign dest_w   = pkt_w[pckg_sz-1 -: 8];
  assign is_bcast = (dest_w == broadcast);
  assign is_uni   = (dest_w < 8'(drvrs)) && (dest_w != {4'd0, gnt_id});

  generate
    for (genvar gi = 0; gi < drvrs; gi++) begin : g_route
      assign pop_d[gi]  = (sel_d == 4'(gi));
      assign push_d[gi] = is_bcast ? (gnt_id != 4'(gi))
                                   : (is_uni && (dest_w == 8'(gi)));
    end
  endgenerate

  // Scheduler FSM; every output is loaded here so all of them are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pop     <= '0;
      push    <= '0;
      D_push  <= '0;
      gnt_id  <= 4'(drvrs - 1);
      busy    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          push <= '0;
          if (sel_vld) begin
            gnt_id  <= sel_d;
            pop     <= pop_d;
            busy    <= 1'b1;
            state_q <= POP;
          end else begin
            pop  <= '0;
            busy <= 1'b0;
          end
        end
        POP: begin
          // FIFO head is consumed at this edge; route it straight into push.
          pop  <= '0;
          push <= push_d;
          if (|push_d) begin
            D_push <= pkt_w;
          end
          busy    <= 1'b1;
          state_q <= XFER;
        end
        XFER: begin
          // gnt_id already holds this source, so it becomes the last grant.
          push    <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          pop     <= '0;
          push    <= '0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef BUS_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Count a drop when the popped packet routes to no destination; saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= 8'h00;
    end else if ((state_q == POP) && !(|push_d) && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_bus_rr_sched.sv
// tb_bus_rr_sched: self-checking bench for bus_rr_sched (drvrs=4, pckg_sz=16).
// Source FIFOs are queues; a transaction-level model predicts grants, routing,
// busy and drop counts from the round-robin and routing rules.
`timescale 1ns/1ps
module tb_bus_rr_sched;
  localparam int N = 4;
  localparam int W = 16;
`ifdef BUS_SCHED_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   pndng = '0;
  logic [N*W-1:0] D_pop = '0;
  logic [N-1:0]   pop;
  logic [N-1:0]   push;
  logic [W-1:0]   D_push;
  logic [3:0]     gnt_id;
  logic           busy;
  logic [7:0]     drop_cnt;

  bus_rr_sched #(.drvrs(N), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .gnt_id(gnt_id),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [W-1:0] fifo [N][$];

  // model state
  int           last_g = N - 1;
  int           drops_m = 0;
  logic [W-1:0] dpush_m = '0;
  bit           pop_prev_m = 1'b0;
  bit           xfer_prev_m = 1'b0;
  logic [N-1:0] exp_mask_m = '0;
  logic [W-1:0] exp_data_m = '0;
  logic [N-1:0] pop_act = '0;

  // observations for directed sequences
  logic [N-1:0] obs_pop, obs_push;
  logic [W-1:0] obs_dpush;
  int           pop_cnt, push_cnt, pop_cyc, push_cyc;
  int           grant_log[$];
  int           grant_cyc[$];

  typedef struct {
    int           src;
    logic [W-1:0] pkt;
    logic [N-1:0] exp_push;
    int           drop_total;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (last + off) % N;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] route(input int src, input logic [W-1:0] pkt);
    int d;
    logic [N-1:0] m;
    d = int'(pkt[15:8]);
    m = '0;
    if (d == 255) begin
      m = '1;
      m[src] = 1'b0;
    end else if (d < N && d != src) begin
      m[d] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    int sel;
    logic [7:0] d;
    sel = $urandom_range(0, 9);
    if (sel <= 5)      d = 8'($urandom_range(0, N - 1));
    else if (sel <= 7) d = 8'hFF;
    else               d = 8'($urandom_range(0, 255));
    return {d, 8'($urandom)};
  endfunction

  function automatic bit fifos_empty();
    for (int i = 0; i < N; i++) if (fifo[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (fifo[i].size() != 0);
      D_pop[i*W +: W] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  endtask

  task automatic clear_obs();
    obs_pop = '0; obs_push = '0; obs_dpush = '0;
    pop_cnt = 0; push_cnt = 0; pop_cyc = 0; push_cyc = 0;
  endtask

  // One clock: FIFOs react to the pop strobe, inputs change #1 after the edge,
  // outputs are checked against the model on the falling edge.
  task automatic tick();
    logic [N-1:0] snap_p;
    bit snap_r, grant_now, xfer_now;
    int g;
    snap_p = pndng;
    snap_r = reset;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pop_act[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    drive();
    @(negedge clk);
    cyc++;
    pop_act = pop;
    if (pop != 0) begin obs_pop |= pop; pop_cnt++; pop_cyc = cyc; end
    if (push != 0) begin obs_push |= push; push_cnt++; push_cyc = cyc; obs_dpush = D_push; end
    if (snap_r) begin
      chk("rst_pop", 32'(pop), 0);
      chk("rst_push", 32'(push), 0);
      chk("rst_dpush", 32'(D_push), 0);
      chk("rst_gnt", 32'(gnt_id), N - 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      last_g = N - 1; drops_m = 0; dpush_m = '0;
      pop_prev_m = 1'b0; xfer_prev_m = 1'b0;
    end else begin
      xfer_now = pop_prev_m;
      if (xfer_now) begin
        if (exp_mask_m == 0) begin
          if (drops_m < 255) drops_m++;
        end else begin
          dpush_m = exp_data_m;
        end
        chk("push", 32'(push), 32'(exp_mask_m));
        $display("xfer src=%0d pkt=%h push=%b%s", last_g, exp_data_m, push,
                 (exp_mask_m == 0) ? " dropped" : "");
      end else begin
        chk("push_idle", 32'(push), 0);
      end
      chk("d_push", 32'(D_push), 32'(dpush_m));
      grant_now = !pop_prev_m && !xfer_prev_m && (snap_p != 0);
      if (grant_now) begin
        g = rr_pick(snap_p, last_g);
        chk("pop", 32'(pop), 32'(1 << g));
        chk("gnt_id", 32'(gnt_id), g);
        exp_data_m = (fifo[g].size() != 0) ? fifo[g][0] : '0;
        exp_mask_m = route(g, exp_data_m);
        last_g = g;
        grant_log.push_back(g);
        grant_cyc.push_back(cyc);
      end else begin
        chk("pop_idle", 32'(pop), 0);
      end
      chk("busy", 32'(busy), 32'(grant_now || xfer_now));
      chk("drop_cnt", 32'(drop_cnt), DROP_EN ? drops_m : 0);
      pop_prev_m = grant_now;
      xfer_prev_m = xfer_now;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int start;
    int t;

    vecs[0] = '{0, 16'h0700, 4'b0000, 1};
    vecs[1] = '{0, 16'h0011, 4'b0000, 2};
    vecs[2] = '{1, 16'h02AB, 4'b0100, 2};
    vecs[3] = '{2, 16'hFF55, 4'b1011, 2};
    vecs[4] = '{3, 16'h0112, 4'b0010, 2};
    vecs[5] = '{0, 16'h0399, 4'b1000, 2};
    vecs[6] = '{3, 16'h03C3, 4'b0000, 3};
    vecs[7] = '{1, 16'hFFEE, 4'b1101, 3};
    vecs[8] = '{2, 16'h0400, 4'b0000, 4};
    vecs[9] = '{1, 16'hFE01, 4'b0000, 5};

    drive();
    do_reset();

    // single-packet routing table
    for (int v = 0; v < 10; v++) begin
      clear_obs();
      start = cyc;
      fifo[vecs[v].src].push_back(vecs[v].pkt);
      repeat (6) tick();
      chk("vec_pop", 32'(obs_pop), 32'(1 << vecs[v].src));
      chk("vec_pop_cnt", pop_cnt, 1);
      chk("vec_pop_latency", pop_cyc - start, 2);
      chk("vec_push", 32'(obs_push), 32'(vecs[v].exp_push));
      chk("vec_push_cnt", push_cnt, (vecs[v].exp_push != 0) ? 1 : 0);
      if (vecs[v].exp_push != 0) begin
        chk("vec_dpush", 32'(obs_dpush), 32'(vecs[v].pkt));
        chk("vec_push_latency", push_cyc - pop_cyc, 1);
      end
      chk("vec_drop", 32'(drop_cnt), DROP_EN ? vecs[v].drop_total : 0);
    end

    // reset during the POP cycle abandons the packet
    do_reset();
    clear_obs();
    fifo[2].push_back(16'h0055);
    tick();
    tick();
    chk("rstmid_pop", 32'(pop), 32'b0100);
    clear_obs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rstmid_no_push", push_cnt, 0);
    chk("rstmid_no_pop", pop_cnt, 0);
    chk("rstmid_lost", fifo[2].size(), 0);
    base = grant_log.size();
    clear_obs();
    fifo[3].push_back(16'h0233);
    fifo[0].push_back(16'h0122);
    repeat (10) tick();
    chk("rstmid_grants", grant_log.size() - base, 2);
    if (grant_log.size() > base) chk("rstmid_first_grant", grant_log[base], 0);
    chk("rstmid_push", 32'(obs_push), 32'b0110);

    // round-robin fairness and 3-cycle throughput
    do_reset();
    base = grant_log.size();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++)
        fifo[i].push_back({8'((i + 1) % N), 8'(k * 16 + i)});
    repeat (30) tick();
    chk("rr_count", grant_log.size() - base, 8);
    for (int k = 0; k < 8 && base + k < grant_log.size(); k++) begin
      chk("rr_order", grant_log[base + k], k % N);
      if (k > 0) begin
        chk("rr_spacing", grant_cyc[base + k] - grant_cyc[base + k - 1], 3);
        chk("rr_no_repeat", 32'(grant_log[base + k] != grant_log[base + k - 1]), 1);
      end
    end

    // drop counter saturation
    for (int k = 0; k < 300; k++) fifo[k % N].push_back({8'h07, 8'(k)});
    t = 0;
    while (t < 2000 && !(fifos_empty() && !busy)) begin
      tick();
      t++;
    end
    repeat (4) tick();
    chk("sat_drained", 32'(fifos_empty()), 1);
    chk("sat_drop", 32'(drop_cnt), DROP_EN ? 255 : 0);

    // randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int s;
        s = $urandom_range(0, N - 1);
        if (fifo[s].size() < 6) fifo[s].push_back(rand_pkt());
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    t = 0;
    while (t < 500 && !(fifos_empty() && !busy)) begin
      tick();
      t++;
    end
    repeat (4) tick();
    chk("rand_drained", 32'(fifos_empty()), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
